// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the round-robin UART transmitter arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a requester index / round-robin pointer (never below one bit).
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_priority_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PW      = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      winner,
  output logic               any
);

  logic [NUM_REQ-1:0] rot_req;
  logic [PW-1:0]      rot_idx [NUM_REQ];

  // Slot gi of the rotated view holds requester (ptr + gi) mod NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [PW:0] sum;
    assign sum         = {1'b0, ptr} + (PW+1)'(gi);
    assign rot_idx[gi] = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        winner = rot_idx[k];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional WAIT_BUSY timeout with ARB_ERR pulse: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int TIMEOUT_CYC = 4,
  localparam int GW          = ptr_width(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            CFG_PAR_EN,
  input  logic [NUM_REQ-1:0]            CFG_PAR_TYP,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYP,
  input  logic                          TX_BUSY,
  output logic [GW-1:0]                 GRANT_ID,
  output logic                          ARB_BUSY,
  output logic                          ARB_ERR
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
  end

  arb_state_e            state_reg;
  logic [GW-1:0]         rr_ptr_reg;
  logic [GW-1:0]         grant_id_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  dv_reg;
  logic                  arb_busy_reg;
  logic [NUM_REQ-1:0]    ack_reg;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]    win_onehot;
  logic [GW-1:0]         win_idx;
  logic [GW-1:0]         ptr_next;
  logic                  win_any;
  logic                  grant_go;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_bytes[gi]  = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    assign win_onehot[gi] = (win_idx == GW'(gi));
  end

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (REQ_VALID),
    .ptr    (rr_ptr_reg),
    .winner (win_idx),
    .any    (win_any)
  );

  assign ptr_next = (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + GW'(1);
  // A transmitter still busy from before a reset blocks new grants.
  assign grant_go = (state_reg == IDLE) && win_any && !TX_BUSY;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= PAR_EVEN;
      dv_reg       <= 1'b0;
      arb_busy_reg <= 1'b0;
      ack_reg      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_reg   <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      dv_reg  <= 1'b0;
      ack_reg <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (grant_go) begin
            data_reg     <= req_bytes[win_idx];
            par_en_reg   <= CFG_PAR_EN[win_idx];
            par_typ_reg  <= CFG_PAR_TYP[win_idx] ? PAR_ODD : PAR_EVEN;
            grant_id_reg <= win_idx;
            rr_ptr_reg   <= ptr_next;
            dv_reg       <= 1'b1;
            ack_reg      <= win_onehot;
            arb_busy_reg <= 1'b1;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          state_reg <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          // The LOAD cycle itself counts toward the timeout window.
          to_cnt_reg <= TO_W'(1);
`endif
        end
        WAIT_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
          if (TX_BUSY) begin
            state_reg <= WAIT_DONE;
          end else if (to_cnt_reg >= TO_W'(TIMEOUT_CYC - 1)) begin
            err_reg      <= 1'b1;
            arb_busy_reg <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
`else
          if (TX_BUSY) begin
            state_reg <= WAIT_DONE;
          end
`endif
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            arb_busy_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          arb_busy_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign REQ_ACK       = ack_reg;
  assign TX_P_DATA     = data_reg;
  assign TX_DATA_VALID = dv_reg;
  assign TX_PAR_EN     = par_en_reg;
  assign TX_PAR_TYP    = par_typ_reg;
  assign GRANT_ID      = grant_id_reg;
  assign ARB_BUSY      = arb_busy_reg;
`ifdef UART_ARB_TIMEOUT_EN
  assign ARB_ERR       = err_reg;
`else
  assign ARB_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple cycle-level transmitter model.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  REQ_VALID = '0;
  logic [31:0] REQ_DATA = '0;
  logic [3:0]  CFG_PAR_EN = '0;
  logic [3:0]  CFG_PAR_TYP = '0;
  logic [3:0]  REQ_ACK;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID;
  logic        TX_PAR_EN;
  logic        TX_PAR_TYP;
  logic        TX_BUSY = 1'b0;
  logic [1:0]  GRANT_ID;
  logic        ARB_BUSY;
  logic        ARB_ERR;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tx_cnt = 0;
  bit tx_respond = 1'b1;
  logic [3:0] hold = '0;
  int base;

  int gid_q[$];
  int data_q[$];
  int pen_q[$];
  int ptyp_q[$];
  int len_q[$];
  int frame_q[$];
  int cyc_q[$];

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (8),
    .TIMEOUT_CYC (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .REQ_VALID     (REQ_VALID),
    .REQ_DATA      (REQ_DATA),
    .CFG_PAR_EN    (CFG_PAR_EN),
    .CFG_PAR_TYP   (CFG_PAR_TYP),
    .REQ_ACK       (REQ_ACK),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .TX_PAR_EN     (TX_PAR_EN),
    .TX_PAR_TYP    (TX_PAR_TYP),
    .TX_BUSY       (TX_BUSY),
    .GRANT_ID      (GRANT_ID),
    .ARB_BUSY      (ARB_BUSY),
    .ARB_ERR       (ARB_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic pen, input logic typ);
    REQ_DATA[i*8 +: 8] = d;
    CFG_PAR_EN[i]      = pen;
    CFG_PAR_TYP[i]     = typ;
  endtask

  // One clock: sample at the falling edge, log grants, run TX and requester models.
  task automatic step();
    logic [10:0] fr;
    int flen;
    @(negedge CLK);
    cyc++;
    if (REQ_ACK != 4'b0000 && !TX_DATA_VALID) check_eq("stray_ack", REQ_ACK, 0);
    if (TX_DATA_VALID) begin
      check_eq("ack_matches_grant", REQ_ACK, 32'(1) << GRANT_ID);
      check_eq("dv_while_tx_busy", TX_BUSY, 0);
      if (TX_PAR_EN) fr = {1'b1, (TX_PAR_TYP ? ~(^TX_P_DATA) : ^TX_P_DATA), TX_P_DATA, 1'b0};
      else           fr = {2'b01, TX_P_DATA, 1'b0};
      flen = TX_PAR_EN ? 11 : 10;
      gid_q.push_back(int'(GRANT_ID));
      data_q.push_back(int'(TX_P_DATA));
      pen_q.push_back(int'(TX_PAR_EN));
      ptyp_q.push_back(int'(TX_PAR_TYP));
      len_q.push_back(flen);
      frame_q.push_back(int'(fr));
      cyc_q.push_back(cyc);
      $display("grant cyc=%0d id=%0d data=%02h par_en=%0d par_typ=%0d frame=%03h",
               cyc, GRANT_ID, TX_P_DATA, TX_PAR_EN, TX_PAR_TYP, fr);
    end
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) TX_BUSY = 1'b0;
    end else if (TX_DATA_VALID && tx_respond) begin
      TX_BUSY = 1'b1;
      tx_cnt  = flen;
    end
    for (int i = 0; i < 4; i++) begin
      if (REQ_ACK[i] && !hold[i]) REQ_VALID[i] = 1'b0;
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (gid_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (gid_q.size() < n) check_eq("grant_timeout", gid_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((ARB_BUSY || TX_BUSY) && k < budget) begin
      step();
      k++;
    end
    if (ARB_BUSY || TX_BUSY) check_eq("idle_timeout", {ARB_BUSY, TX_BUSY}, 0);
  endtask

  task automatic check_grant(input string tag, input int idx, input int eid, input int edata,
                             input int epen, input int eptyp);
    if (idx < gid_q.size()) begin
      check_eq({tag, "_id"}, gid_q[idx], eid);
      check_eq({tag, "_data"}, data_q[idx], edata);
      check_eq({tag, "_par_en"}, pen_q[idx], epen);
      check_eq({tag, "_par_typ"}, ptyp_q[idx], eptyp);
    end else begin
      check_eq({tag, "_missing"}, gid_q.size(), idx + 1);
    end
  endtask

  task automatic check_outputs_clear(input string tag);
    check_eq({tag, "_ack"}, REQ_ACK, 0);
    check_eq({tag, "_p_data"}, TX_P_DATA, 0);
    check_eq({tag, "_dv"}, TX_DATA_VALID, 0);
    check_eq({tag, "_par_en"}, TX_PAR_EN, 0);
    check_eq({tag, "_par_typ"}, TX_PAR_TYP, 0);
    check_eq({tag, "_grant_id"}, GRANT_ID, 0);
    check_eq({tag, "_arb_busy"}, ARB_BUSY, 0);
    check_eq({tag, "_arb_err"}, ARB_ERR, 0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_outputs_clear("reset");
    RST = 1'b1;
    step();

    // Test 1: single request, FE with even parity
    base = gid_q.size();
    set_req(0, 8'hFE, 1'b1, 1'b0);
    hold = 4'b0000;
    REQ_VALID = 4'b0001;
    step();
    check_eq("t1_dv", TX_DATA_VALID, 1);
    check_eq("t1_ack", REQ_ACK, 4'b0001);
    check_eq("t1_p_data", TX_P_DATA, 8'hFE);
    check_eq("t1_par_en", TX_PAR_EN, 1);
    check_eq("t1_par_typ", TX_PAR_TYP, 0);
    check_eq("t1_arb_busy", ARB_BUSY, 1);
    step();
    check_eq("t1_dv_low", TX_DATA_VALID, 0);
    check_eq("t1_ack_low", REQ_ACK, 0);
    check_eq("t1_data_hold", TX_P_DATA, 8'hFE);
    wait_idle(100);
    if (base < len_q.size()) begin
      check_eq("t1_frame_len", len_q[base], 11);
      check_eq("t1_frame", frame_q[base], 11'h7FC);
    end else begin
      check_eq("t1_missing", gid_q.size(), base + 1);
    end

    // Idle reset so the pointer starts again at 0
    RST = 1'b0;
    #1;
    check_eq("idle_reset_grant_id", GRANT_ID, 0);
    check_eq("idle_reset_p_data", TX_P_DATA, 0);
    step();
    RST = 1'b1;
    step();

    // Test 2: four continuous requesters rotate 0,1,2,3,0
    base = gid_q.size();
    set_req(0, 8'h11, 1'b0, 1'b0);
    set_req(1, 8'h22, 1'b0, 1'b0);
    set_req(2, 8'h33, 1'b0, 1'b0);
    set_req(3, 8'h44, 1'b0, 1'b0);
    hold = 4'b1111;
    REQ_VALID = 4'b1111;
    wait_grants(base + 5, 400);
    REQ_VALID = 4'b0000;
    hold = 4'b0000;
    check_grant("t2_g0", base + 0, 0, 8'h11, 0, 0);
    check_grant("t2_g1", base + 1, 1, 8'h22, 0, 0);
    check_grant("t2_g2", base + 2, 2, 8'h33, 0, 0);
    check_grant("t2_g3", base + 3, 3, 8'h44, 0, 0);
    check_grant("t2_g4", base + 4, 0, 8'h11, 0, 0);
    for (int k = 1; k < 5; k++) begin
      if (base + k < cyc_q.size()) check_eq("t2_grant_gap", cyc_q[base+k] - cyc_q[base+k-1], 12);
    end
    wait_idle(100);

    // Test 3: per-requester parity (odd vs disabled)
    base = gid_q.size();
    set_req(1, 8'hAA, 1'b1, 1'b1);
    set_req(2, 8'hAA, 1'b0, 1'b0);
    REQ_VALID = 4'b0110;
    wait_grants(base + 2, 200);
    wait_idle(100);
    check_grant("t3_g0", base + 0, 1, 8'hAA, 1, 1);
    check_grant("t3_g1", base + 1, 2, 8'hAA, 0, 0);
    if (base + 1 < len_q.size()) begin
      check_eq("t3_len_odd", len_q[base], 11);
      check_eq("t3_len_nopar", len_q[base+1], 10);
      check_eq("t3_frame_odd", frame_q[base], 11'h754);
      check_eq("t3_frame_nopar", frame_q[base+1], 11'h354);
    end

    // Test 4: requester 3 withdraws while requester 0 is in flight
    base = gid_q.size();
    set_req(0, 8'h5A, 1'b1, 1'b0);
    REQ_VALID = 4'b0001;
    wait_grants(base + 1, 50);
    step();
    step();
    set_req(3, 8'h3C, 1'b0, 1'b0);
    REQ_VALID[3] = 1'b1;
    repeat (3) step();
    REQ_VALID[3] = 1'b0;
    wait_idle(100);
    repeat (4) step();
    check_eq("t4_grant_count", gid_q.size(), base + 1);
    check_grant("t4_g0", base, 0, 8'h5A, 1, 0);
    check_eq("t4_last_winner", GRANT_ID, 0);
    check_eq("t4_arb_err", ARB_ERR, 0);

    // Test 5: reset during WAIT_DONE, then requester 2 wins from pointer 0
    base = gid_q.size();
    set_req(2, 8'h66, 1'b1, 1'b1);
    REQ_VALID = 4'b0100;
    wait_grants(base + 1, 50);
    repeat (3) step();
    check_eq("t5_pre_arb_busy", ARB_BUSY, 1);
    check_eq("t5_pre_tx_busy", TX_BUSY, 1);
    set_req(2, 8'h99, 1'b0, 1'b0);
    set_req(3, 8'h33, 1'b0, 1'b0);
    REQ_VALID = 4'b1100;
    #2;
    RST = 1'b0;
    #1;
    check_outputs_clear("t5_async");
    step();
    step();
    RST = 1'b1;
    wait_grants(base + 3, 200);
    check_grant("t5_g1", base + 1, 2, 8'h99, 0, 0);
    check_grant("t5_g2", base + 2, 3, 8'h33, 0, 0);
    wait_idle(100);

`ifdef UART_ARB_TIMEOUT_EN
    // Test 6: TX_BUSY stuck low times out and the next requester is served
    begin
      int k;
      int load_cyc;
      base = gid_q.size();
      tx_respond = 1'b0;
      set_req(0, 8'h10, 1'b0, 1'b0);
      set_req(1, 8'h20, 1'b0, 1'b0);
      REQ_VALID = 4'b0011;
      wait_grants(base + 1, 50);
      load_cyc = (base < cyc_q.size()) ? cyc_q[base] : cyc;
      k = 0;
      while (!ARB_ERR && k < 20) begin
        step();
        k++;
      end
      check_eq("t6_err_seen", ARB_ERR, 1);
      check_eq("t6_err_delay", cyc - load_cyc, 4);
      check_eq("t6_arb_busy", ARB_BUSY, 0);
      step();
      check_eq("t6_err_pulse", ARB_ERR, 0);
      wait_grants(base + 2, 50);
      check_grant("t6_g0", base + 0, 0, 8'h10, 0, 0);
      check_grant("t6_g1", base + 1, 1, 8'h20, 0, 0);
      tx_respond = 1'b1;
      wait_idle(100);
    end
`else
    check_eq("final_arb_err", ARB_ERR, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
